axi_fsrc_up_initiator: RTL

- Initiator (master) side of the codebase's up_* register interface (up_wreq/up_waddr/up_wdata/up_wack, up_rreq/up_raddr/up_rdata/up_rack).
- Takes single read/write commands from a valid/ready command port, issues exactly one up_* transaction per command, waits for the acknowledge with a timeout, and returns a buffered response.
- Sits between a local controller (e.g. an FSRC sequencer setup engine) and the *_regmap responder blocks, allowing hardware-driven register programming without AXI.

---
 rtl/axi_fsrc_up_initiator.sv | 132 +++++++++++++
 1 files changed

// File: rtl/axi_fsrc_up_initiator.sv
// Initiator side of the up_* register bus: turns one valid/ready command into one
// up_wreq/up_rreq transaction, waits for the matching ack (with timeout) and buffers the response.
module axi_fsrc_up_initiator #(
  parameter int          ADDR_WIDTH     = 14,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_DEAD
) (
  input  logic                  up_clk,
  input  logic                  up_rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [15:0]           err_cnt,
  output logic                  up_wreq,
  output logic [ADDR_WIDTH-1:0] up_waddr,
  output logic [31:0]           up_wdata,
  input  logic                  up_wack,
  output logic                  up_rreq,
  output logic [ADDR_WIDTH-1:0] up_raddr,
  input  logic [31:0]           up_rdata,
  input  logic                  up_rack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam int         CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT_CYCLES);

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [1:0]    state;
  logic          wr_q;
  logic [CW-1:0] tcnt;
  logic [CW:0]   tcnt_next;
  logic          ack;
  logic          expire;

  // Reset asserts immediately but releases two clocks after up_rstn rises.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Only the ack matching the outstanding request type is ever looked at.
  assign ack       = wr_q ? up_wack : up_rack;
  assign tcnt_next = {1'b0, tcnt} + 1'b1;
  assign expire    = (TIMEOUT_CYCLES > 0) && (tcnt_next == TO_LIM);

  assign cmd_ready = (state == S_IDLE) && rst_n;
  assign rsp_valid = (state == S_RSP);
  assign busy      = (state != S_IDLE);
  assign up_wreq   = (state == S_REQ) && wr_q;
  assign up_rreq   = (state == S_REQ) && !wr_q;

  always_ff @(posedge up_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      tcnt      <= '0;
      up_waddr  <= '0;
      up_wdata  <= '0;
      up_raddr  <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            wr_q <= cmd_wr;
            if (cmd_wr) begin
              up_waddr <= cmd_addr;
              up_wdata <= cmd_wdata;
            end else begin
              up_raddr <= cmd_addr;
            end
            state <= S_REQ;
          end
        end
        S_REQ: begin
          tcnt <= '0;
          if (ack) begin
            rsp_rdata <= wr_q ? 32'd0 : up_rdata;
            rsp_error <= 1'b0;
            state     <= S_RSP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An ack arriving in the expiry cycle takes priority over the timeout.
          if (ack) begin
            rsp_rdata <= wr_q ? 32'd0 : up_rdata;
            rsp_error <= 1'b0;
            state     <= S_RSP;
          end else if (expire) begin
            rsp_rdata <= wr_q ? 32'd0 : ERR_DATA;
            rsp_error <= 1'b1;
            if (err_cnt != 16'hFFFF) begin
              err_cnt <= err_cnt + 16'd1;
            end
            state <= S_RSP;
          end else begin
            tcnt <= tcnt_next[CW-1:0];
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
